exu_div: RTL and testbench
==========================

EXU_DIV -- requirements
Module: exu_div

Interface
REQ-001 Parameter XLEN, default 32: operand/result width.
REQ-002 Parameter TAG_W, default 8: instruction tag width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 div_valid  input  1  issue strobe (issued instruction legal AND div).
REQ-006 div_rs1_data  input  XLEN  dividend.
REQ-007 div_rs2_data  input  XLEN  divisor.
REQ-008 div_rd_addr  input  5  destination register.
REQ-009 div_rem  input  1  1 = REM/REMU result, 0 = DIV/DIVU result.
REQ-010 div_unsign  input  1  1 = unsigned operands.
REQ-011 div_instr_tag  input  TAG_W  tag carried to writeback.
REQ-012 pipe_flush  input  1  abort any in-flight operation.
REQ-013 div_busy  output  1  operation in progress; drives decode-stage stall.
REQ-014 div_wb_data  output  XLEN  result.
REQ-015 div_wb_rd_addr  output  5  result destination.
REQ-016 div_wb_rd_wr_en  output  1  one-cycle writeback strobe.
REQ-017 div_wb_instr_tag  output  TAG_W  tag of completing instruction.

Function
REQ-018 FSM states IDLE, CALC, FIX, DONE; IDLE after reset.
REQ-019 Accept when state is IDLE or DONE, div_valid=1, pipe_flush=0; operands, rd_addr, rem, unsign, tag captured at that edge.
REQ-020 On accept, operands converted to magnitudes (signed mode), sign flags for quotient/remainder stored; next state CALC.
REQ-021 CALC: radix-2 restoring, one quotient bit per cycle, exactly XLEN cycles (5-bit-plus counter, XLEN-1 down to 0), then FIX.
REQ-022 FIX: apply signs (quotient negated if operand signs differ, remainder takes dividend sign), select quotient or remainder, register wb outputs; next state DONE.
REQ-023 DONE lasts one cycle: div_wb_rd_wr_en=1; next state IDLE unless a new accept occurs.
REQ-024 Normal latency: div_wb_rd_wr_en asserted exactly XLEN+2 cycles after accept cycle.
REQ-025 div_busy = 1 in CALC and FIX only; 0 in IDLE and DONE (registered, no combinational path from inputs).
REQ-026 Divisor zero: quotient = all ones (both modes), remainder = dividend; no sign negation of quotient.
REQ-027 Signed overflow (dividend = 1<<(XLEN-1), divisor = all ones): quotient = dividend, remainder = 0.
REQ-028 div_valid while div_busy=1 is ignored; no state change.
REQ-029 pipe_flush=1: next state IDLE from any state, no writeback strobe in following cycle; flush wins over simultaneous div_valid.
REQ-030 div_wb_data, div_wb_rd_addr, div_wb_instr_tag hold last value outside DONE.

Reset
REQ-031 rst=1 at any edge, including mid-CALC: state IDLE, div_busy=0, div_wb_rd_wr_en=0, div_wb_data=0, div_wb_rd_addr=0, div_wb_instr_tag=0, counter=0.
REQ-032 No writeback strobe for an operation interrupted by reset.

Configuration
REQ-033 Macro DIV_EARLY_OUT_EN defined: divisor-zero, signed-overflow, and |dividend| < |divisor| cases skip CALC/FIX; accept goes directly to DONE, strobe 1 cycle after accept, div_busy never asserted.
REQ-034 Macro undefined: every operation takes XLEN+2 cycles; results identical to REQ-026/REQ-027.

Verification
REQ-035 DIVU 100/7 -> div_wb_data=14 at accept+34; REMU same operands -> 2; div_busy high cycles accept+1..accept+33.
REQ-036 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF.
REQ-037 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5; strobe at accept+1 with DIV_EARLY_OUT_EN, accept+34 without.
REQ-038 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-039 pipe_flush at accept+10 -> div_busy=0 next cycle, no strobe; new DIVU 9/3 accepted next cycle -> 3 at its accept+34.
REQ-040 rst at accept+5 -> all outputs zero next cycle, no strobe; back-to-back accept in DONE cycle gives two strobes 34 cycles apart.

Source files
------------

// File: rtl/exu_div.sv
// exu_div : iterative integer divider for DIV/DIVU/REM/REMU.
//
// Radix-2 restoring divider. Each operation is accepted in IDLE or DONE,
// runs XLEN CALC cycles (one quotient bit per cycle), one FIX cycle to apply
// signs and select the result, then a one-cycle DONE writeback strobe.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   div_valid           issue strobe (legal divide instruction)
//   div_rs1_data/rs2    dividend / divisor
//   div_rd_addr         destination register
//   div_rem             1: remainder result, 0: quotient result
//   div_unsign          1: unsigned operands
//   div_instr_tag       tag carried to writeback
//   pipe_flush          abort any in-flight operation
//   div_busy            operation in progress (registered)
//   div_wb_*            registered writeback outputs, strobe in DONE only
//
// Build option
//   DIV_EARLY_OUT_EN    when defined, divide-by-zero, signed overflow and
//                       |dividend| < |divisor| complete straight to DONE.
module exu_div #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_valid,
  input  logic [XLEN-1:0]  div_rs1_data,
  input  logic [XLEN-1:0]  div_rs2_data,
  input  logic [4:0]       div_rd_addr,
  input  logic             div_rem,
  input  logic             div_unsign,
  input  logic [TAG_W-1:0] div_instr_tag,
  input  logic             pipe_flush,
  output logic             div_busy,
  output logic [XLEN-1:0]  div_wb_data,
  output logic [4:0]       div_wb_rd_addr,
  output logic             div_wb_rd_wr_en,
  output logic [TAG_W-1:0] div_wb_instr_tag
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    quo_q, quo_d;
  logic [XLEN-1:0]    rem_q, rem_d;
  logic [XLEN-1:0]    dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               sel_rem_q, sel_rem_d;
  logic [4:0]         rd_q, rd_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
  logic               busy_q, busy_d;
  logic               wr_en_q, wr_en_d;

  logic               accept;
  logic               early;
  logic               a_neg, b_neg, b_zero;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic [XLEN:0]      shifted, diff;
  logic [XLEN-1:0]    q_fix, r_fix;

  // Operand conditioning on the issue-side inputs.
  always_comb begin
    accept = div_valid && !pipe_flush && (state_q == S_IDLE || state_q == S_DONE);
    a_neg  = !div_unsign && div_rs1_data[XLEN-1];
    b_neg  = !div_unsign && div_rs2_data[XLEN-1];
    b_zero = (div_rs2_data == '0);
    a_mag  = a_neg ? ('0 - div_rs1_data) : div_rs1_data;
    b_mag  = b_neg ? ('0 - div_rs2_data) : div_rs2_data;
  end

`ifdef DIV_EARLY_OUT_EN
  logic            ovf;
  logic [XLEN-1:0] eo_quo, eo_rem;
  always_comb begin
    ovf    = !div_unsign && (div_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
             && (div_rs2_data == '1);
    early  = b_zero || ovf || (a_mag < b_mag);
    eo_quo = b_zero ? '1 : (ovf ? div_rs1_data : '0);
    eo_rem = ovf ? '0 : div_rs1_data;
  end
`else
  always_comb early = 1'b0;
`endif

  // State and datapath register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      rd_q      <= '0;
      tag_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_tag_q  <= '0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
      rd_q      <= rd_d;
      tag_q     <= tag_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_tag_q  <= wb_tag_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (pipe_flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (accept)                state_d = early ? S_DONE : S_CALC;
          else if (state_q == S_DONE) state_d = S_IDLE;
        end
        S_CALC:  if (cnt_q == '0) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output logic.
  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    rd_d      = rd_q;
    tag_d     = tag_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_tag_d  = wb_tag_q;

    // quo_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    q_fix   = neg_quo_q ? ('0 - quo_q) : quo_q;
    r_fix   = neg_rem_q ? ('0 - rem_q) : rem_q;

    if (accept) begin
      quo_d     = a_mag;
      rem_d     = '0;
      dvs_d     = b_mag;
      cnt_d     = CNT_W'(XLEN - 1);
      // A zero divisor yields an all-ones quotient that must stay unsigned.
      neg_quo_d = (a_neg ^ b_neg) && !b_zero;
      neg_rem_d = a_neg;
      sel_rem_d = div_rem;
      rd_d      = div_rd_addr;
      tag_d     = div_instr_tag;
`ifdef DIV_EARLY_OUT_EN
      if (early) begin
        wb_data_d = div_rem ? eo_rem : eo_quo;
        wb_rd_d   = div_rd_addr;
        wb_tag_d  = div_instr_tag;
      end
`endif
    end else if (state_q == S_CALC) begin
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shifted[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end else if (state_q == S_FIX && !pipe_flush) begin
      wb_data_d = sel_rem_q ? r_fix : q_fix;
      wb_rd_d   = rd_q;
      wb_tag_d  = tag_q;
    end

    busy_d  = (state_d == S_CALC) || (state_d == S_FIX);
    wr_en_d = (state_d == S_DONE);
  end

  always_comb begin
    div_busy         = busy_q;
    div_wb_rd_wr_en  = wr_en_q;
    div_wb_data      = wb_data_q;
    div_wb_rd_addr   = wb_rd_q;
    div_wb_instr_tag = wb_tag_q;
  end

endmodule

// File: tb/tb_exu_div.sv
module tb_exu_div;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT  = 1;
  localparam int EO_BUSY = 0;
`else
  localparam int EO_LAT  = 34;
  localparam int EO_BUSY = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid;
  logic [31:0] div_rs1_data;
  logic [31:0] div_rs2_data;
  logic [4:0]  div_rd_addr;
  logic        div_rem;
  logic        div_unsign;
  logic [7:0]  div_instr_tag;
  logic        pipe_flush;
  logic        div_busy;
  logic [31:0] div_wb_data;
  logic [4:0]  div_wb_rd_addr;
  logic        div_wb_rd_wr_en;
  logic [7:0]  div_wb_instr_tag;

  int errors = 0;
  int checks = 0;

  exu_div #(.XLEN(32), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .div_valid(div_valid),
    .div_rs1_data(div_rs1_data), .div_rs2_data(div_rs2_data),
    .div_rd_addr(div_rd_addr), .div_rem(div_rem), .div_unsign(div_unsign),
    .div_instr_tag(div_instr_tag), .pipe_flush(pipe_flush),
    .div_busy(div_busy), .div_wb_data(div_wb_data),
    .div_wb_rd_addr(div_wb_rd_addr), .div_wb_rd_wr_en(div_wb_rd_wr_en),
    .div_wb_instr_tag(div_wb_instr_tag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one operation in the current cycle (cycle 0) and follows it until
  // the strobe. Returns the strobe cycle (-1 if none within budget), captured
  // outputs and busy statistics. A garbage issue is driven in cycle inj (0=off).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic rem, input logic uns, input logic [4:0] rd,
                       input logic [7:0] tag, input int inj,
                       output logic [31:0] data, output logic [4:0] rd_o,
                       output logic [7:0] tag_o, output int lat,
                       output int busy_cnt, output int busy_first,
                       output int busy_last);
    div_valid = 1'b1; div_rs1_data = a; div_rs2_data = b; div_rem = rem;
    div_unsign = uns; div_rd_addr = rd; div_instr_tag = tag;
    step();
    div_valid = 1'b0;
    lat = -1; busy_cnt = 0; busy_first = 0; busy_last = 0;
    data = '0; rd_o = '0; tag_o = '0;
    for (int n = 1; n <= 60; n++) begin
      if (div_busy) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = n;
        busy_last = n;
      end
      if (div_wb_rd_wr_en) begin
        lat = n; data = div_wb_data; rd_o = div_wb_rd_addr; tag_o = div_wb_instr_tag;
        break;
      end
      if (n == inj) begin
        div_valid = 1'b1; div_rs1_data = 32'h0000_1234; div_rs2_data = 32'd1;
        div_rem = 1'b0; div_instr_tag = 8'hEE; div_rd_addr = 5'd31;
      end
      step();
      div_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; div_valid = 1'b0; pipe_flush = 1'b0; div_rs1_data = '0;
    div_rs2_data = '0; div_rd_addr = '0; div_rem = 1'b0; div_unsign = 1'b0;
    div_instr_tag = '0;
    step(); step(); step();
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", div_busy); end
    checks++; if (div_wb_rd_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", div_wb_rd_wr_en); end
    checks++; if (div_wb_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", div_wb_data); end
    checks++; if (div_wb_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", div_wb_rd_addr); end
    checks++; if (div_wb_instr_tag !== 8'h0) begin errors++; $display("FAIL reset_tag: got %h expected 0", div_wb_instr_tag); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    logic [31:0] d; logic [4:0] r; logic [7:0] t; int lat, bc, bf, bl;
    do_op(32'd100, 32'd7, 1'b0, 1'b1, 5'd3, 8'h11, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h expected %h", d, 32'd14); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency: got %0d expected 34", lat); end
    checks++; if (bc !== 33 || bf !== 1 || bl !== 33) begin errors++; $display("FAIL divu_busy_window: got %0d cycles %0d..%0d expected 33 cycles 1..33", bc, bf, bl); end
    checks++; if (r !== 5'd3 || t !== 8'h11) begin errors++; $display("FAIL divu_rd_tag: got rd=%0d tag=%h expected rd=3 tag=11", r, t); end
    // Strobe is one cycle wide and results hold afterwards.
    step();
    checks++; if (div_wb_rd_wr_en !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b expected 0", div_wb_rd_wr_en); end
    checks++; if (div_wb_data !== 32'd14 || div_wb_rd_addr !== 5'd3) begin errors++; $display("FAIL wb_hold: got %h/%0d expected 0000000e/3", div_wb_data, div_wb_rd_addr); end
    do_op(32'd100, 32'd7, 1'b1, 1'b1, 5'd4, 8'h12, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h expected %h", d, 32'd2); end
    step();
    do_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, 5'd5, 8'h13, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_max_16: got %h expected 0fffffff", d); end
    step();
    do_op(32'hFFFF_FFFF, 32'h10, 1'b1, 1'b1, 5'd5, 8'h14, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'hF) begin errors++; $display("FAIL remu_max_16: got %h expected 0000000f", d); end
    step();
  endtask

  task automatic test_signed();
    logic [31:0] d; logic [4:0] r; logic [7:0] t; int lat, bc, bf, bl;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 5'd6, 8'h21, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2: got %h expected fffffffd", d); end
    step();
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 5'd6, 8'h22, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2: got %h expected ffffffff", d); end
    step();
    do_op(32'd20, 32'hFFFF_FFFA, 1'b0, 1'b0, 5'd7, 8'h23, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_20_m6: got %h expected fffffffd", d); end
    step();
    do_op(32'd20, 32'hFFFF_FFFA, 1'b1, 1'b0, 5'd7, 8'h24, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL rem_20_m6: got %h expected 00000002", d); end
    step();
  endtask

  task automatic test_div_zero();
    logic [31:0] d; logic [4:0] r; logic [7:0] t; int lat, bc, bf, bl;
    do_op(32'd5, 32'd0, 1'b0, 1'b0, 5'd8, 8'h31, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_5_0: got %h expected ffffffff", d); end
    checks++; if (lat !== EO_LAT) begin errors++; $display("FAIL div0_latency: got %0d expected %0d", lat, EO_LAT); end
    checks++; if (bc !== EO_BUSY) begin errors++; $display("FAIL div0_busy: got %0d expected %0d", bc, EO_BUSY); end
    step();
    do_op(32'd5, 32'd0, 1'b1, 1'b0, 5'd8, 8'h32, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL rem_5_0: got %h expected 00000005", d); end
    step();
    do_op(32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 5'd8, 8'h33, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m5_0: got %h expected ffffffff", d); end
    step();
    do_op(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0, 5'd8, 8'h34, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'hFFFF_FFFB) begin errors++; $display("FAIL rem_m5_0: got %h expected fffffffb", d); end
    step();
    do_op(32'hDEAD_BEEF, 32'd0, 1'b0, 1'b1, 5'd8, 8'h35, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_x_0: got %h expected ffffffff", d); end
    step();
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic [4:0] r; logic [7:0] t; int lat, bc, bf, bl;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 5'd9, 8'h41, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf: got %h expected 80000000", d); end
    checks++; if (lat !== EO_LAT) begin errors++; $display("FAIL ovf_latency: got %0d expected %0d", lat, EO_LAT); end
    step();
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd9, 8'h42, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rem_ovf: got %h expected 00000000", d); end
    step();
  endtask

  task automatic test_busy_ignore();
    logic [31:0] d; logic [4:0] r; logic [7:0] t; int lat, bc, bf, bl;
    do_op(32'd100, 32'd7, 1'b0, 1'b1, 5'd10, 8'h51, 5, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'd14 || t !== 8'h51 || r !== 5'd10) begin errors++; $display("FAIL busy_ignore: got %h tag=%h rd=%0d expected 0000000e tag=51 rd=10", d, t, r); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL busy_ignore_latency: got %0d expected 34", lat); end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] d; logic [4:0] r; logic [7:0] t; int lat, bc, bf, bl, strobes, busys;
    div_valid = 1'b1; div_rs1_data = 32'd100; div_rs2_data = 32'd7; div_rem = 1'b0;
    div_unsign = 1'b1; div_rd_addr = 5'd11; div_instr_tag = 8'h61;
    step();
    div_valid = 1'b0;
    for (int n = 1; n < 10; n++) step();
    pipe_flush = 1'b1; div_valid = 1'b1;
    step();
    pipe_flush = 1'b0; div_valid = 1'b0;
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", div_busy); end
    checks++; if (div_wb_rd_wr_en !== 1'b0) begin errors++; $display("FAIL flush_strobe: got %b expected 0", div_wb_rd_wr_en); end
    do_op(32'd9, 32'd3, 1'b0, 1'b1, 5'd12, 8'h62, 0, d, r, t, lat, bc, bf, bl);
    checks++; if (d !== 32'd3 || t !== 8'h62) begin errors++; $display("FAIL flush_next_op: got %h tag=%h expected 00000003 tag=62", d, t); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL flush_next_latency: got %0d expected 34", lat); end
    step();
    // Flush wins over a simultaneous issue in IDLE.
    div_valid = 1'b1; pipe_flush = 1'b1; div_rs1_data = 32'd100; div_rs2_data = 32'd7;
    step();
    div_valid = 1'b0; pipe_flush = 1'b0;
    strobes = 0; busys = 0;
    for (int n = 0; n < 40; n++) begin
      if (div_wb_rd_wr_en) strobes++;
      if (div_busy) busys++;
      step();
    end
    checks++; if (strobes !== 0 || busys !== 0) begin errors++; $display("FAIL flush_over_valid: got strobes=%0d busy=%0d expected 0/0", strobes, busys); end
  endtask

  task automatic test_reset_mid();
    int strobes;
    div_valid = 1'b1; div_rs1_data = 32'd100; div_rs2_data = 32'd7; div_rem = 1'b0;
    div_unsign = 1'b1; div_rd_addr = 5'd13; div_instr_tag = 8'h71;
    step();
    div_valid = 1'b0;
    for (int n = 1; n < 5; n++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (div_busy !== 1'b0 || div_wb_rd_wr_en !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got busy=%b wr_en=%b expected 0/0", div_busy, div_wb_rd_wr_en); end
    checks++; if (div_wb_data !== 32'h0 || div_wb_rd_addr !== 5'd0 || div_wb_instr_tag !== 8'h0) begin errors++; $display("FAIL midreset_wb: got %h/%0d/%h expected 0/0/0", div_wb_data, div_wb_rd_addr, div_wb_instr_tag); end
    strobes = 0;
    for (int n = 0; n < 40; n++) begin
      if (div_wb_rd_wr_en) strobes++;
      step();
    end
    checks++; if (strobes !== 0) begin errors++; $display("FAIL midreset_no_strobe: got %0d expected 0", strobes); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2; logic [4:0] r1, r2; logic [7:0] t1, t2;
    int l1, l2, bc, bf, bl;
    do_op(32'd100, 32'd7, 1'b0, 1'b1, 5'd14, 8'h81, 0, d1, r1, t1, l1, bc, bf, bl);
    // Still in the DONE cycle: the next issue is accepted here.
    do_op(32'd9, 32'd3, 1'b0, 1'b1, 5'd15, 8'h82, 0, d2, r2, t2, l2, bc, bf, bl);
    checks++; if (d1 !== 32'd14 || l1 !== 34) begin errors++; $display("FAIL b2b_first: got %h lat=%0d expected 0000000e lat=34", d1, l1); end
    checks++; if (d2 !== 32'd3 || r2 !== 5'd15 || t2 !== 8'h82) begin errors++; $display("FAIL b2b_second: got %h rd=%0d tag=%h expected 00000003 rd=15 tag=82", d2, r2, t2); end
    checks++; if (l2 !== 34) begin errors++; $display("FAIL b2b_spacing: got %0d expected 34", l2); end
    step();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
